// File: rtl/bram_frame_writer.sv
// Thresholds a streamed RGB frame into a 1-bit BRAM image, addressed as {y[8:0], x[9:0]}.
// Define FRAME_CLEAR_EN to zero the whole image after each accepted start, before capture begins.
module bram_frame_writer #(
    parameter int HPIX = 640,
    parameter int VPIX = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [29:0] pix_data,
    input  logic [11:0] threshold,
    output logic [18:0] bram_addr,
    output logic        bram_din,
    output logic        bram_we,
    output logic        busy,
    output logic        done
);

    localparam logic [9:0] X_LAST = 10'(HPIX - 1);
    localparam logic [8:0] Y_LAST = 9'(VPIX - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SOF = 3'd1,
        CAPTURE  = 3'd2,
        DONE     = 3'd3
`ifdef FRAME_CLEAR_EN
        ,
        CLEAR    = 3'd4
`endif
    } state_t;

    state_t      state, state_next;
    logic [9:0]  x, x_next;
    logic [8:0]  y, y_next;
    logic [11:0] thr, thr_next;
    logic [18:0] addr_next;
    logic        we_next, din_next;

    logic [11:0] lum;
    logic [9:0]  wx;
    logic [8:0]  wy;

    // A sof pixel always lands at the origin, whatever the counters say
    assign lum = 12'(pix_data[29:20]) + 12'(pix_data[19:10]) + 12'(pix_data[9:0]);
    assign wx  = pix_sof ? 10'd0 : x;
    assign wy  = pix_sof ? 9'd0 : y;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            thr       <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= 1'b0;
        end else begin
            state     <= state_next;
            x         <= x_next;
            y         <= y_next;
            thr       <= thr_next;
            bram_we   <= we_next;
            bram_addr <= addr_next;
            bram_din  <= din_next;
        end
    end

    always_comb begin
        state_next = state;
        x_next     = x;
        y_next     = y;
        thr_next   = thr;
        we_next    = 1'b0;
        addr_next  = bram_addr;
        din_next   = bram_din;

        case (state)
            IDLE: begin
                x_next = '0;
                y_next = '0;
                if (start) begin
                    thr_next = threshold;
`ifdef FRAME_CLEAR_EN
                    state_next = CLEAR;
`else
                    state_next = WAIT_SOF;
`endif
                end
            end

`ifdef FRAME_CLEAR_EN
            CLEAR: begin
                we_next   = 1'b1;
                addr_next = {y, x};
                din_next  = 1'b0;
                if (x == X_LAST) begin
                    x_next = '0;
                    if (y == Y_LAST) begin
                        y_next     = '0;
                        state_next = WAIT_SOF;
                    end else begin
                        y_next = y + 9'd1;
                    end
                end else begin
                    x_next = x + 10'd1;
                end
            end
`endif

            WAIT_SOF, CAPTURE: begin
                if (pix_valid && (pix_sof || state == CAPTURE)) begin
                    we_next   = 1'b1;
                    addr_next = {wy, wx};
                    din_next  = (lum >= thr);
                    if (wx == X_LAST && wy == Y_LAST) begin
                        x_next     = '0;
                        y_next     = '0;
                        state_next = DONE;
                    end else if (wx == X_LAST) begin
                        x_next     = '0;
                        y_next     = wy + 9'd1;
                        state_next = CAPTURE;
                    end else begin
                        x_next     = wx + 10'd1;
                        y_next     = wy;
                        state_next = CAPTURE;
                    end
                end
            end

            DONE: state_next = IDLE;

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bram_frame_writer.sv
// Randomized self-checking bench for bram_frame_writer on a reduced 640x8 frame.
// The expected write stream is derived from a linear pixel index, not from the counters.
module tb_bram_frame_writer;

    localparam int HPIX = 640;
    localparam int VPIX = 8;
    localparam int NPIX = HPIX * VPIX;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pix_valid;
    logic        pix_sof;
    logic [29:0] pix_data;
    logic [11:0] threshold;
    logic [18:0] bram_addr;
    logic        bram_din;
    logic        bram_we;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    bram_frame_writer #(.HPIX(HPIX), .VPIX(VPIX)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_data  (pix_data),
        .threshold (threshold),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_we   (bram_we),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] pix_addr(input int k);
        return {9'(k / HPIX), 10'(k % HPIX)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts a start and, when clearing is compiled in, checks the full zero sweep
    task automatic begin_frame(input logic [11:0] thr);
        start     = 1'b1;
        threshold = thr;
        step();
        start     = 1'b0;
        threshold = 12'($urandom);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL start_busy: got %b expected 1", busy);
        end
`ifdef FRAME_CLEAR_EN
        for (int i = 0; i < NPIX; i++) begin
            step();
            n_cmp++;
            if (bram_we !== 1'b1 || bram_addr !== pix_addr(i) || bram_din !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL clear_write %0d: got we=%b addr=%h din=%b expected we=1 addr=%h din=0",
                         i, bram_we, bram_addr, bram_din, pix_addr(i));
            end
        end
`endif
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b1;
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        pix_data  = '1;
        threshold = '0;
        repeat (3) step();
        n_cmp++;
        if ({bram_we, bram_addr, bram_din, busy, done} !== 23'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got we=%b addr=%h din=%b busy=%b done=%b expected all 0",
                     bram_we, bram_addr, bram_din, busy, done);
        end
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        reset     = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || bram_we !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL idle_after_reset: got busy=%b we=%b expected 0 0", busy, bram_we);
        end
    endtask

    task automatic test_threshold();
        begin_frame(12'd1536);
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        pix_data  = {10'd512, 10'd512, 10'd512};
        step();
        n_cmp++;
        if (bram_we !== 1'b1 || bram_addr !== 19'h00000 || bram_din !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL thr_equal: got we=%b addr=%h din=%b expected 1 00000 1", bram_we, bram_addr, bram_din);
        end
        pix_sof  = 1'b0;
        pix_data = {10'd511, 10'd511, 10'd511};
        step();
        n_cmp++;
        if (bram_we !== 1'b1 || bram_addr !== 19'h00001 || bram_din !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL thr_below: got we=%b addr=%h din=%b expected 1 00001 0", bram_we, bram_addr, bram_din);
        end
        pix_valid = 1'b0;
        step();
        n_cmp++;
        if (bram_we !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL idle_gap_we: got %b expected 0", bram_we);
        end
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL thr_abort: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    // mode 0: every cycle valid, 1: valid toggles 1/0, 2: random valid
    task automatic run_frame(input int mode, input bit resync, input bit poke);
        logic [11:0] thr;
        logic [18:0] exp_addr;
        int  k, cyc, drops, r, g, b;
        bit  cap, fin, resync_done, v, s, exp_we, exp_din, exp_done;

        thr = 12'($urandom_range(0, 3069));
        begin_frame(thr);
        k = 0; cyc = 0; drops = 3; cap = 0; fin = 0; resync_done = 0;
        exp_addr = '0; exp_din = 0;
        while (!fin && cyc < 6 * NPIX) begin
            cyc++;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 1;
                default: v = 1'($urandom);
            endcase
            r = $urandom_range(0, 1023);
            g = $urandom_range(0, 1023);
            b = $urandom_range(0, 1023);
            s = 1'b0;
            if (!v) begin
                s = 1'($urandom);
            end else if (!cap) begin
                s = (drops == 0);
                if (drops > 0) drops--;
            end else if (resync && !resync_done && k == 3 * HPIX + 320) begin
                s = 1'b1;
                resync_done = 1'b1;
            end
            start     = poke && cap && (k == 1000);
            threshold = 12'($urandom);
            pix_valid = v;
            pix_sof   = s;
            pix_data  = {10'(r), 10'(g), 10'(b)};

            exp_we = 0;
            exp_done = 0;
            if (v && (s || cap)) begin
                if (s) k = 0;
                cap      = 1;
                exp_we   = 1;
                exp_addr = pix_addr(k);
                exp_din  = (r + g + b) >= int'(thr);
                if (k == NPIX - 1) exp_done = 1;
                else k++;
            end

            step();
            n_cmp++;
            if (bram_we !== exp_we) begin
                n_bad++;
                $display("[TB] FAIL frame_we cyc %0d: got %b expected %b", cyc, bram_we, exp_we);
            end
            if (exp_we) begin
                n_cmp++;
                if (bram_addr !== exp_addr || bram_din !== exp_din) begin
                    n_bad++;
                    $display("[TB] FAIL frame_write cyc %0d: got addr=%h din=%b expected addr=%h din=%b",
                             cyc, bram_addr, bram_din, exp_addr, exp_din);
                end
            end
            n_cmp++;
            if (done !== exp_done || busy !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL frame_status cyc %0d: got done=%b busy=%b expected done=%b busy=1",
                         cyc, done, busy, exp_done);
            end
            fin = exp_done;
        end
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL frame_timeout: got %0d cycles expected completion", cyc);
        end
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || bram_we !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL frame_end: got busy=%b done=%b we=%b expected 0 0 0", busy, done, bram_we);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(0, 1'b0, 1'b1);
    endtask

    task automatic test_gapped_stream();
        run_frame(1, 1'b0, 1'b0);
    endtask

    task automatic test_resync();
        run_frame(2, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int stop_k;
        stop_k = 5 * HPIX + 100;
        begin_frame(12'd0);
        for (int k = 0; k <= stop_k; k++) begin
            pix_valid = 1'b1;
            pix_sof   = (k == 0);
            pix_data  = 30'($urandom);
            step();
        end
        n_cmp++;
        if (bram_we !== 1'b1 || bram_addr !== {9'd5, 10'd100}) begin
            n_bad++;
            $display("[TB] FAIL pre_reset_write: got we=%b addr=%h expected 1 %h", bram_we, bram_addr, {9'd5, 10'd100});
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL async_abort: got we=%b busy=%b done=%b expected 0 0 0", bram_we, busy, done);
        end
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pix_valid = 1'b1;
            pix_sof   = 1'($urandom);
            pix_data  = 30'($urandom);
            step();
            n_cmp++;
            if (bram_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL post_abort %0d: got we=%b done=%b busy=%b expected 0 0 0",
                         i, bram_we, done, busy);
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_back_to_back();
        test_gapped_stream();
        test_resync();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
